// File: rtl/relu_maxpool.sv
// relu_maxpool: streaming ReLU followed by a 2x2 / stride-2 max-pool.
//
// Consumes one feature map in raster order and emits the pooled map in raster order.
// Frames are delimited only by the internal row/col counters, so they run back to back.
//
// Ports
//   clk        in   1       clock, rising edge
//   rstb       in   1       asynchronous active-low reset
//   in_valid   in   1       in_data is valid
//   in_ready   out  1       stage accepts in_data this cycle (combinational)
//   in_data    in   DATA_W  signed conv output pixel
//   out_valid  out  1       out_data is valid
//   out_ready  in   1       downstream accepts out_data
//   out_data   out  DATA_W  pooled pixel (always >= 0)
//   out_last   out  1       with out_valid: last pooled pixel of the frame
module relu_maxpool #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FMAP_SIZE = 13
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned OUT_SIZE  = FMAP_SIZE / 2;
    localparam int unsigned POOL_SPAN = 2 * OUT_SIZE;
    // One extra value of headroom so POOL_SPAN itself is representable.
    localparam int unsigned CNT_W     = $clog2(FMAP_SIZE + 1);
    localparam int unsigned LB_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [CNT_W-1:0] FMAP_LAST = CNT_W'(FMAP_SIZE - 1);
    localparam logic [CNT_W-1:0] SPAN      = CNT_W'(POOL_SPAN);
    localparam logic [CNT_W-1:0] SPAN_LAST = CNT_W'(POOL_SPAN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Signed maximum at DATA_W bits.
    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [CNT_W-1:0]         col;
    logic [CNT_W-1:0]         row;
    logic signed [DATA_W-1:0] hold;
    logic signed [DATA_W-1:0] linebuf [OUT_SIZE];

    logic                     accept_c;
    logic                     active_c;
    logic                     emit_c;
    logic                     last_c;
    logic [LB_W-1:0]          lb_idx_c;
    logic signed [DATA_W-1:0] relu_c;
    logic signed [DATA_W-1:0] pair_max_c;
    logic signed [DATA_W-1:0] quad_max_c;

    // Handshake: a held output blocks input unless it is drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // Pixels beyond the pooled span (odd FMAP_SIZE) are counted but ignored.
    assign active_c = (col < SPAN) && (row < SPAN);
    assign lb_idx_c = LB_W'(col >> 1);

    assign relu_c     = in_data[DATA_W-1] ? '0 : $signed(in_data);
    assign pair_max_c = smax(hold, relu_c);
    assign quad_max_c = smax(pair_max_c, linebuf[lb_idx_c]);

    // Bottom-right pixel of a window completes it.
    assign emit_c = accept_c && active_c && col[0] && row[0];
    assign last_c = (row == SPAN_LAST) && (col == SPAN_LAST);

    // Raster position counters, advanced on accept only.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            col <= '0;
            row <= '0;
        end else if (accept_c) begin
            if (col == FMAP_LAST) begin
                col <= '0;
                row <= (row == FMAP_LAST) ? '0 : row + CNT_ONE;
            end else begin
                col <= col + CNT_ONE;
            end
        end
    end

    // Left-column pixel of the current window row.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hold <= '0;
        end else if (accept_c && active_c && !col[0]) begin
            hold <= relu_c;
        end
    end

    // Top-row pair maxima; every entry is written on the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (accept_c && active_c && col[0] && !row[0]) begin
            linebuf[lb_idx_c] <= pair_max_c;
        end
    end

    // Output register: a new window result may replace a value consumed in the same cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (emit_c) begin
            out_valid <= 1'b1;
            out_data  <= quad_max_c;
            out_last  <= last_c;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Self-checking bench for relu_maxpool: directed frames, scoreboard of expected pooled outputs.
module tb_relu_maxpool;

    localparam int FS = 13;
    localparam int OS = FS / 2;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstb;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic signed [31:0] img [FS][FS];

    bit stall_arm  = 1'b0;
    bit stall_done = 1'b0;

    relu_maxpool #(.DATA_W(32), .FMAP_SIZE(FS)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] relu(input logic signed [31:0] v);
        return (v < 0) ? 32'sd0 : v;
    endfunction

    // Reference: max over the ReLU of the four pixels of the window whose top-left is (r, c).
    function automatic logic [31:0] win_max(input int r, input int c);
        logic signed [31:0] m;
        m = relu(img[r][c]);
        if (relu(img[r][c+1]) > m)   m = relu(img[r][c+1]);
        if (relu(img[r+1][c]) > m)   m = relu(img[r+1][c]);
        if (relu(img[r+1][c+1]) > m) m = relu(img[r+1][c+1]);
        return m;
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < FS; r++)
            for (int c = 0; c < FS; c++)
                img[r][c] = 32'(13 * r + c);
    endtask

    task automatic fill_const(input logic signed [31:0] v);
        for (int r = 0; r < FS; r++)
            for (int c = 0; c < FS; c++)
                img[r][c] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < FS; r++)
            for (int c = 0; c < FS; c++)
                img[r][c] = $signed($urandom);
    endtask

    // Drive one pixel, holding it until accepted; inputs change only on the falling edge.
    task automatic send_pixel(input logic [31:0] v);
        bit ok;
        in_valid = 1'b1;
        in_data  = v;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            #1;
            ok = in_ready;
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    // Stream the first npix raster pixels of img, pushing each window result as its last pixel goes out.
    task automatic send_frame(input int npix);
        for (int i = 0; i < npix; i++) begin
            int r;
            int c;
            exp_t e;
            r = i / FS;
            c = i % FS;
            if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * OS) && (c < 2 * OS)) begin
                e.data = win_max(r - 1, c - 1);
                e.last = (r == 2 * OS - 1) && (c == 2 * OS - 1);
                sb.push_back(e);
            end
            send_pixel(img[r][c]);
        end
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: compare every consumed output against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rstb && out_valid && out_ready) begin
            exp_t e;
            check("output_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    // Backpressure: hold out_ready low for 5 clocks after the first out_valid once armed.
    always @(negedge clk) begin
        if (stall_arm && out_valid) begin
            stall_arm = 1'b0;
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                #1;
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_data", out_data, 32'd14);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                @(negedge clk);
            end
            out_ready  = 1'b1;
            stall_done = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rstb = 1'b1;
        @(negedge clk);

        // Ramp
        fill_ramp();
        send_frame(FS * FS);
        drain("ramp_drain");

        // All negative
        fill_const(-32'sd7);
        send_frame(FS * FS);
        drain("neg_drain");

        // Mixed-sign and extreme windows
        fill_random();
        img[0][0] = -32'sd5; img[0][1] = 32'sd3;  img[1][0] = -32'sd2; img[1][1] = -32'sd9;
        img[0][2] = -32'sd1; img[0][3] = -32'sd2; img[1][2] = -32'sd3; img[1][3] = -32'sd4;
        img[0][4] = 32'sh7FFF_FFFF; img[0][5] = 32'sd0; img[1][4] = 32'sd0; img[1][5] = 32'sd0;
        img[2][0] = 32'sh8000_0000; img[2][1] = -32'sd1; img[3][0] = 32'sd1; img[3][1] = 32'sh8000_0000;
        check("model_mixed", win_max(0, 0), 32'd3);
        check("model_allneg", win_max(0, 2), 32'd0);
        check("model_maxpos", win_max(0, 4), 32'h7FFF_FFFF);
        send_frame(FS * FS);
        drain("mixed_drain");

        // Backpressure on the ramp frame
        fill_ramp();
        stall_done = 1'b0;
        stall_arm  = 1'b1;
        send_frame(FS * FS);
        drain("stall_drain");
        check("stall_seen", 32'(stall_done), 32'd1);

        // Edge discard: last row/column poisoned
        fill_ramp();
        for (int i = 0; i < FS; i++) begin
            img[FS-1][i] = 32'sd1000;
            img[i][FS-1] = 32'sd1000;
        end
        send_frame(FS * FS);
        drain("edge_drain");

        // Reset mid-frame after 50 pixels, then a clean ramp frame
        fill_ramp();
        send_frame(50);
        drain("partial_drain");
        rstb = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_last", 32'(out_last), 32'd0);
        rstb = 1'b1;
        send_frame(FS * FS);
        drain("post_reset_drain");

        // 16 back-to-back random frames with random out_ready pauses absent
        for (int f = 0; f < 16; f++) begin
            fill_random();
            send_frame(FS * FS);
        end
        drain("b2b_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
